// File: rtl/mac_operand_sequencer.sv
// Operand feeder for mac_unit: buffers operand pairs, issues one multiply at a time,
// and returns the accumulator as a dot-product result when the last element completes.
module mac_operand_sequencer #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic             in_rs1_signed,
  input  logic             in_rs2_signed,
  input  logic             in_last,
  output logic [31:0]      mac_rs1,
  output logic [31:0]      mac_rs2,
  output logic             mac_rs1_signed,
  output logic             mac_rs2_signed,
  output logic             mac_start,
  output logic             mac_clear,
  input  logic             mac_acc_valid,
  input  logic             mac_acc_busy,
  input  logic [63:0]      mac_result,
  output logic             dot_valid,
  input  logic             dot_ready,
  output logic [63:0]      dot_result,
  output logic [CNT_W-1:0] dot_count,
  output logic             error
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        rs1_signed;
    logic        rs2_signed;
    logic        last;
  } entry_t;

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, DONE} state_t;

  entry_t          mem [DEPTH];
  entry_t          entry_in, hold;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_nxt;
  logic            push, pop, empty;
  state_t          state, state_nxt;
  logic            first_elem;
  logic [TW-1:0]   wait_cnt;
  logic            acc_ok, tmo;

  assign entry_in = '{rs1: in_rs1, rs2: in_rs2, rs1_signed: in_rs1_signed,
                      rs2_signed: in_rs2_signed, last: in_last};
  assign push  = in_valid & in_ready;
  assign empty = (count == '0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // in_ready is registered so it reads 0 throughout reset and whenever the FIFO is full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      in_ready <= (count_nxt != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  // Head is popped into the holding register on entry to ISSUE, so operands are
  // already stable during the mac_start cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    acc_ok    = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: if (!empty && !mac_acc_busy) begin
        if (first_elem) state_nxt = CLEAR;
        else begin
          state_nxt = ISSUE;
          pop       = 1'b1;
        end
      end
      CLEAR: begin
        state_nxt = ISSUE;
        pop       = 1'b1;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // acc_valid in the first WAIT cycle belongs to an older operation
        if (mac_acc_valid && wait_cnt != '0) begin
          acc_ok = 1'b1;
          if (hold.last) state_nxt = DONE;
          else if (!empty && !mac_acc_busy) begin
            state_nxt = ISSUE;
            pop       = 1'b1;
          end else state_nxt = IDLE;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          tmo       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: if (dot_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold       <= '0;
      first_elem <= 1'b1;
      wait_cnt   <= '0;
      dot_result <= '0;
      dot_count  <= '0;
      error      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (pop) hold <= mem[rd_ptr];
      if (state == CLEAR) dot_count <= '0;
      else if (acc_ok && dot_count != {CNT_W{1'b1}}) dot_count <= dot_count + 1'b1;
      if ((acc_ok && hold.last) || tmo) dot_result <= mac_result;
      if (acc_ok && !hold.last) first_elem <= 1'b0;
      else if (state == DONE && dot_ready) first_elem <= 1'b1;
      if (tmo) error <= 1'b1;
    end
  end

  assign mac_rs1        = hold.rs1;
  assign mac_rs2        = hold.rs2;
  assign mac_rs1_signed = hold.rs1_signed;
  assign mac_rs2_signed = hold.rs2_signed;
  assign mac_start      = (state == ISSUE);
  assign mac_clear      = (state == CLEAR);
  assign dot_valid      = (state == DONE);

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with a behavioural mac_unit and a result scoreboard.
module tb_mac_operand_sequencer;
  localparam int DEPTH = 4, CNT_W = 8, TIMEOUT = 64;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic in_valid = 0, in_ready, in_rs1_signed = 0, in_rs2_signed = 0, in_last = 0;
  logic [31:0] in_rs1 = 0, in_rs2 = 0, mac_rs1, mac_rs2;
  logic mac_rs1_signed, mac_rs2_signed, mac_start, mac_clear;
  logic mac_acc_valid, mac_acc_busy, dot_valid, dot_ready = 0, error;
  logic [63:0] mac_result, dot_result;
  logic [CNT_W-1:0] dot_count;

  mac_operand_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_signed(in_rs1_signed),
    .in_rs2_signed(in_rs2_signed), .in_last(in_last),
    .mac_rs1(mac_rs1), .mac_rs2(mac_rs2), .mac_rs1_signed(mac_rs1_signed),
    .mac_rs2_signed(mac_rs2_signed), .mac_start(mac_start), .mac_clear(mac_clear),
    .mac_acc_valid(mac_acc_valid), .mac_acc_busy(mac_acc_busy), .mac_result(mac_result),
    .dot_valid(dot_valid), .dot_ready(dot_ready), .dot_result(dot_result),
    .dot_count(dot_count), .error(error));

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sa, input logic sb);
    logic [63:0] ea, eb;
    ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Behavioural mac_unit: result lands a few cycles after start; stub mode never answers.
  logic [63:0] m_acc, m_prod;
  logic        m_busy, m_vld, stub = 0;
  logic [1:0]  m_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acc <= 0; m_prod <= 0; m_busy <= 0; m_vld <= 0; m_cnt <= 0;
    end else begin
      m_vld <= 0;
      if (mac_clear) m_acc <= 0;
      if (mac_start && !stub) begin
        m_prod <= mul64(mac_rs1, mac_rs2, mac_rs1_signed, mac_rs2_signed);
        m_busy <= 1; m_cnt <= 3;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_acc <= m_acc + m_prod; m_vld <= 1; m_busy <= 0;
        end
      end
    end
  end
  assign mac_acc_valid = m_vld;
  assign mac_acc_busy  = m_busy;
  assign mac_result    = m_acc;

  typedef struct { logic [63:0] res; logic [CNT_W-1:0] cnt; } exp_t;
  exp_t        sbq[$];
  logic [63:0] acc_m = 0;
  int          cnt_m = 0;
  bit          sb_en = 1;
  int          checks = 0, errors = 0;
  int          clr_cnt = 0, start_cnt = 0;
  longint      cyc = 0, clr_cyc = 0, start_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (mac_clear) begin clr_cnt <= clr_cnt + 1; clr_cyc <= cyc; end
    if (mac_start) begin
      start_cnt <= start_cnt + 1; start_cyc <= cyc;
      chk("start_while_busy", 64'(mac_acc_busy), 64'(0));
    end
    if (dot_valid && dot_ready) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'(1));
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("dot_result", dot_result, e.res);
        chk("dot_count", 64'(dot_count), 64'(e.cnt));
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic sa, input logic sb, input logic l);
    int n = 0;
    exp_t e;
    in_rs1 = a; in_rs2 = b; in_rs1_signed = sa; in_rs2_signed = sb; in_last = l;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    chk("push_accept", 64'(in_ready), 64'(1));
    tick;
    in_valid = 0;
    if (sb_en) begin
      acc_m += mul64(a, b, sa, sb);
      cnt_m++;
      if (l) begin
        e.res = acc_m; e.cnt = CNT_W'(cnt_m);
        sbq.push_back(e);
        acc_m = 0; cnt_m = 0;
      end
    end
  endtask

  longint dv_cyc;
  task automatic wait_dot;
    int n = 0;
    @(negedge clk);
    while (!dot_valid && n < 300) begin @(negedge clk); n++; end
    dv_cyc = cyc;
    chk("wait_dot", 64'(dot_valid), 64'(1));
  endtask

  task automatic drain;
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin tick; n++; end
    chk("drain", 64'(sbq.size()), 64'(0));
    tick;
  endtask

  int c0, s0, nst;
  exp_t ex;
  initial begin
    // Reset state
    repeat (3) tick;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_dot_valid", 64'(dot_valid), 64'(0));
    chk("rst_mac_start", 64'(mac_start), 64'(0));
    chk("rst_mac_clear", 64'(mac_clear), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_dot_result", dot_result, 64'(0));
    rst = 1;
    tick;
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));

    // Single unsigned vector, result held without dot_ready
    c0 = clr_cnt; s0 = start_cnt;
    push(2, 3, 0, 0, 0); push(4, 5, 0, 0, 0); push(6, 7, 0, 0, 1);
    wait_dot;
    chk("t1_clears", 64'(clr_cnt - c0), 64'(1));
    chk("t1_starts", 64'(start_cnt - s0), 64'(3));
    repeat (5) tick;
    chk("t1_held_valid", 64'(dot_valid), 64'(1));
    chk("t1_held_result", dot_result, 64'(68));
    chk("t1_held_count", 64'(dot_count), 64'(3));
    dot_ready = 1;
    tick;
    dot_ready = 0;
    chk("t1_valid_dropped", 64'(dot_valid), 64'(0));

    // Signed vector
    dot_ready = 1;
    c0 = clr_cnt; s0 = start_cnt;
    push(32'hFFFFFFFF, 5, 1, 1, 0); push(3, 32'hFFFFFFFE, 1, 1, 1);
    drain;
    chk("t2_clears", 64'(clr_cnt - c0), 64'(1));
    chk("t2_starts", 64'(start_cnt - s0), 64'(2));

    // Back-pressure: DONE held, FIFO fills to DEPTH, then two vectors run
    dot_ready = 0;
    push(10, 10, 0, 0, 1);
    wait_dot;
    tick;
    c0 = clr_cnt; s0 = start_cnt;
    push(1, 2, 0, 0, 0); push(3, 4, 0, 0, 0); push(5, 6, 0, 0, 0); push(7, 8, 0, 0, 1);
    chk("t3_full_ready", 64'(in_ready), 64'(0));
    repeat (3) tick;
    chk("t3_full_ready_held", 64'(in_ready), 64'(0));
    chk("t3_no_start_in_done", 64'(start_cnt - s0), 64'(0));
    dot_ready = 1;
    push(2, 2, 0, 0, 0); push(3, 3, 0, 0, 1);
    drain;
    chk("t3_clears", 64'(clr_cnt - c0), 64'(2));
    chk("t3_starts", 64'(start_cnt - s0), 64'(6));

    // Starvation mid-vector: no re-clear
    c0 = clr_cnt; s0 = start_cnt;
    push(1, 1, 0, 0, 0);
    repeat (20) tick;
    chk("t4_idle_no_dot", 64'(dot_valid), 64'(0));
    push(9, 9, 0, 0, 1);
    drain;
    chk("t4_clears", 64'(clr_cnt - c0), 64'(1));
    chk("t4_starts", 64'(start_cnt - s0), 64'(2));

    // Timeout with a silent mac_unit
    stub = 1; dot_ready = 0; sb_en = 0;
    push(5, 5, 0, 0, 1);
    ex.res = 0; ex.cnt = 0; sbq.push_back(ex);
    wait_dot;
    chk("t5_timeout_latency", 64'(dv_cyc - start_cyc), 64'(TIMEOUT + 1));
    chk("t5_error", 64'(error), 64'(1));
    tick;
    dot_ready = 1; stub = 0; sb_en = 1;
    tick;
    push(2, 2, 0, 0, 1);
    drain;
    chk("t5_error_sticky", 64'(error), 64'(1));

    // Reset during WAIT of element 2
    sb_en = 0;
    push(1, 1, 0, 0, 0); push(2, 2, 0, 0, 0); push(3, 3, 0, 0, 1);
    nst = 0;
    for (int n = 0; n < 200 && nst < 2; n++) begin
      @(negedge clk);
      if (mac_start) nst++;
    end
    chk("t6_reached_elem2", 64'(nst), 64'(2));
    tick;
    rst = 0;
    c0 = clr_cnt; s0 = start_cnt;
    @(negedge clk);
    chk("t6_rst_in_ready", 64'(in_ready), 64'(0));
    chk("t6_rst_dot_valid", 64'(dot_valid), 64'(0));
    chk("t6_rst_error", 64'(error), 64'(0));
    chk("t6_rst_dot_result", dot_result, 64'(0));
    chk("t6_rst_dot_count", 64'(dot_count), 64'(0));
    repeat (3) tick;
    chk("t6_no_pulses", 64'((clr_cnt - c0) + (start_cnt - s0)), 64'(0));
    rst = 1;
    tick;
    chk("t6_in_ready_after_rst", 64'(in_ready), 64'(1));
    repeat (5) tick;
    chk("t6_fifo_empty", 64'(start_cnt - s0), 64'(0));
    sb_en = 1;
    c0 = clr_cnt; s0 = start_cnt;
    push(7, 8, 0, 0, 1);
    drain;
    chk("t6_clears", 64'(clr_cnt - c0), 64'(1));
    chk("t6_starts", 64'(start_cnt - s0), 64'(1));
    chk("t6_clear_first", 64'(clr_cyc < start_cyc), 64'(1));

    chk("sb_empty_end", 64'(sbq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Upstream feeder for mac_unit. Buffers operand pairs from a valid/ready stream in a small FIFO and issues them to mac_unit one at a time.
- Pulses clear_acc before the first element of each vector and waits for acc_valid after every start.
- On the element flagged last, it captures the 64-bit accumulator and presents it as a dot-product result over a valid/ready output.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, min 2).
- CNT_W, 8, width of dot_count.
- TIMEOUT, 64, max cycles in WAIT before error is flagged.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO can accept (= !full).
- in_rs1  input  32  operand A.
- in_rs2  input  32  operand B.
- in_rs1_signed  input  1  A signedness.
- in_rs2_signed  input  1  B signedness.
- in_last  input  1  last element of the current vector.
- mac_rs1  output  32  to mac_unit rs1.
- mac_rs2  output  32  to mac_unit rs2.
- mac_rs1_signed  output  1  to mac_unit.
- mac_rs2_signed  output  1  to mac_unit.
- mac_start  output  1  to mac_unit start_mul; 1-cycle pulse.
- mac_clear  output  1  to mac_unit clear_acc; 1-cycle pulse.
- mac_acc_valid  input  1  from mac_unit acc_valid.
- mac_acc_busy  input  1  from mac_unit acc_busy.
- mac_result  input  64  from mac_unit mac_result.
- dot_valid  output  1  dot product available.
- dot_ready  input  1  consumer accepts.
- dot_result  output  64  captured accumulator.
- dot_count  output  CNT_W  elements in the captured vector.
- error  output  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, async): FIFO empty, state IDLE, first_elem=1, all outputs 0. in_ready goes to 1 on the first clock after rst deasserts. error clears only on reset.
- FIFO:
  - Each entry is {rs1, rs2, rs1_signed, rs2_signed, last}.
  - Push when in_valid & in_ready.
  - Pop on the ISSUE transition.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH. No bypass: an entry pushed in cycle N is issuable no earlier than N+1.
  - in_ready = 0 when full, including a cycle that also pops.
- FSM states:
  - IDLE: if FIFO non-empty and !mac_acc_busy, go to CLEAR when first_elem=1, else to ISSUE.
  - CLEAR: mac_clear=1 for exactly 1 cycle, dot_count <= 0, then ISSUE.
  - ISSUE:
    - Pop the head into holding registers, which drive mac_rs1/mac_rs2/mac_*_signed.
    - Assert mac_start for 1 cycle, then go to WAIT.
    - The holding registers stay stable until the next ISSUE.
  - WAIT:
    - Wait for mac_acc_valid. mac_acc_valid in the first WAIT cycle is ignored (stale pulse guard).
    - On acc_valid, dot_count increments, saturating at 2^CNT_W-1.
    - If the held entry's last=1, capture mac_result into dot_result and go to DONE.
    - Otherwise set first_elem=0, then go to ISSUE if FIFO non-empty and !mac_acc_busy, else IDLE.
  - DONE:
    - dot_valid=1; dot_result and dot_count are held.
    - On dot_ready, drop dot_valid, set first_elem=1, go to IDLE.
    - The FIFO keeps accepting input while in DONE.
- Timeout: if WAIT lasts TIMEOUT cycles without mac_acc_valid, set error=1 and go to DONE with the current mac_result (partial result delivered).
- No mac_start is ever issued while mac_acc_busy=1 or while in WAIT or DONE. At most one multiply is outstanding.
- Latency: an entry in the FIFO with the FSM in IDLE reaches mac_start after 2 cycles (IDLE, ISSUE), or 3 cycles if CLEAR is needed.
- Reset mid-operation: everything returns to the reset state. The buffered FIFO contents and any partial vector are discarded, and no pulse is emitted during reset.

Test Plan:
- Single vector: push (2,3),(4,5),(6,7,last), all unsigned, mac_unit connected -> exactly one mac_clear and three mac_start; dot_result=68, dot_count=3, dot_valid held until dot_ready.
- Signed vector: (32'hFFFFFFFF,5,signed/signed),(3,32'hFFFFFFFE,last,signed/signed) -> dot_result=64'hFFFFFFFFFFFFFFF5 (-11), dot_count=2.
- Back-pressure and full:
  - Hold dot_ready=0 while pushing 6 pairs -> in_ready drops after DEPTH=4 accepted and none are lost.
  - Release dot_ready -> second vector starts with a fresh mac_clear, and its result is independent of the first.
- Starvation: push (1,1), wait 20 cycles, push (9,9,last) -> FSM sits in IDLE without re-clearing; dot_result=82.
- Timeout: stub mac_acc_valid=0 -> after 64 WAIT cycles error=1 and dot_valid=1, with error staying 1 until reset.
- Reset mid-vector: assert rst low during WAIT of element 2 -> outputs 0 and FIFO empty; a new vector (7,8,last) yields 56 with a mac_clear first.
